// File: rtl/led_pattern_loader.sv
// Frame parser that streams pattern bytes into the inactive bank of a double-buffered
// pattern RAM and swaps banks only after the whole frame passes its XOR checksum.
module led_pattern_loader #(
  parameter int          DEPTH   = 16,
  parameter int          ADDR_W  = 4,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          TIMEOUT = 2700000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [5:0]        wr_data,
  output logic              active_bank,
  output logic [ADDR_W:0]   pattern_len,
  output logic              commit,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    COMMIT
  } state_t;

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]        DEPTH_B = 8'(DEPTH);

  state_t              state_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [7:0]          chk_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [5:0]          wr_data_q;
  logic                active_bank_q;
  logic [ADDR_W:0]     pattern_len_q;
  logic                commit_q;
  logic                err_q;

  logic accept_d;
  logic in_frame_d;
  logic timeout_d;
  logic last_d;

  assign in_ready   = (state_q != COMMIT);
  assign accept_d   = in_valid && in_ready;
  assign in_frame_d = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  assign timeout_d  = in_frame_d && !accept_d && (cnt_q == TO_LAST);
  assign last_d     = ({1'b0, idx_q} == (len_q - 1'b1));

  // The writer always targets the bank the player is not reading.
  assign wr_bank     = ~active_bank_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign active_bank = active_bank_q;
  assign pattern_len = pattern_len_q;
  assign commit      = commit_q;
  assign err         = err_q;

  // NOTE: all state here is sequential, so every assignment in this block is non-blocking;
  // reads see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      active_bank_q <= 1'b0;
      pattern_len_q <= '0;
      commit_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;

      if (accept_d || !in_frame_d) cnt_q <= '0;
      else                         cnt_q <= cnt_q + 1'b1;

      if (timeout_d) begin
        err_q   <= 1'b1;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept_d && (in_data == SYNC)) state_q <= LEN;
          end
          LEN: begin
            if (accept_d) begin
              if ((in_data == 8'h00) || (in_data > DEPTH_B)) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                len_q   <= in_data[ADDR_W:0];
                idx_q   <= '0;
                chk_q   <= '0;
                state_q <= DATA;
              end
            end
          end
          DATA: begin
            if (accept_d) begin
              chk_q     <= chk_q ^ in_data;
              wr_en_q   <= 1'b1;
              wr_addr_q <= idx_q;
              wr_data_q <= in_data[5:0];
              if (last_d) state_q <= CHK;
              else        idx_q   <= idx_q + 1'b1;
            end
          end
          CHK: begin
            if (accept_d) begin
              if (in_data == chk_q) begin
                commit_q      <= 1'b1;
                active_bank_q <= ~active_bank_q;
                pattern_len_q <= len_q;
                state_q       <= COMMIT;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          COMMIT:  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_loader.sv
// Directed bench for led_pattern_loader: a table of frames with hand-computed results,
// plus hand-written sequences for the inter-byte timeout and a reset in mid-frame.
module tb_led_pattern_loader;

  localparam int         DEPTH   = 16;
  localparam int         ADDR_W  = 4;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        wr_data;
  logic              active_bank;
  logic [ADDR_W:0]   pattern_len;
  logic              commit;
  logic              err;

  led_pattern_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .active_bank(active_bank), .pattern_len(pattern_len), .commit(commit), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [5:0]        data;
    logic              bank;
  } wr_t;

  typedef struct {
    int   start;     // first byte in pool
    int   n;         // bytes in the frame
    int   ds;        // offset of P[0] within the frame
    int   nwr;       // expected RAM writes
    int   end_kind;  // 0 none, 1 commit, 2 err after the last byte
    int   len;       // expected pattern_len afterwards
    logic bank;      // expected active_bank afterwards
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pool[$];
  vec_t        vecs[$];
  wr_t         wq[$];
  int          n_commit = 0;
  int          n_err = 0;
  int          n_overlap = 0;
  int          commit_len = 0;
  logic        commit_bank = 1'b0;
  logic        commit_ready = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) wq.push_back('{addr: wr_addr, data: wr_data, bank: wr_bank});
      if (commit) begin
        n_commit++;
        commit_len   = int'(pattern_len);
        commit_bank  = active_bank;
        commit_ready = in_ready;
      end
      if (err) n_err++;
      if (commit && err) n_overlap++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: got in_ready=0 expected 1 within 10 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic add_rec(input int start, input int n, input int ds, input int nwr,
                         input int end_kind, input int len, input logic bank);
    vecs.push_back('{start: start, n: n, ds: ds, nwr: nwr, end_kind: end_kind,
                     len: len, bank: bank});
  endtask

  task automatic add_vec(input logic [159:0] s, input int n, input int ds, input int nwr,
                         input int end_kind, input int len, input logic bank);
    int st;
    st = pool.size();
    for (int k = 0; k < n; k++) pool.push_back(s[8*(n-1-k) +: 8]);
    add_rec(st, n, ds, nwr, end_kind, len, bank);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   st;
    int   bw;
    int   bc;
    int   be;
    int   k;
    logic got;
    logic prev_bank;
    vec_t v;

    // Frame table; every expected value below is worked out by hand from the frame bytes.
    add_vec({8'hA5, 8'h03, 8'h01, 8'h02, 8'h04, 8'h07}, 6, 2, 3, 1, 3, 1'b1);
    add_vec({8'hA5, 8'h02, 8'h3F, 8'h20, 8'h00}, 5, 2, 2, 2, 3, 1'b1);
    add_vec({8'hA5, 8'h02, 8'h3F, 8'h20, 8'h1F}, 5, 2, 2, 1, 2, 1'b0);
    add_vec({8'hA5, 8'h00}, 2, 2, 0, 2, 2, 1'b0);
    add_vec({8'hA5, 8'h11}, 2, 2, 0, 2, 2, 1'b0);
    add_vec({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hC1, 8'hC1}, 7, 5, 1, 1, 1, 1'b1);
    add_vec({8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hFF}, 5, 2, 2, 1, 2, 1'b0);
    st = pool.size();
    pool.push_back(8'hA5);
    pool.push_back(8'h10);
    for (int i = 0; i < 16; i++) pool.push_back(8'(i));
    pool.push_back(8'h00);
    add_rec(st, 19, 2, 16, 1, 16, 1'b1);

    // Reset state
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_commit", commit, 0);
    check("rst_err", err, 0);
    check("rst_active_bank", active_bank, 0);
    check("rst_pattern_len", pattern_len, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_bank", wr_bank, 1);

    prev_bank = 1'b0;
    for (int vi = 0; vi < vecs.size(); vi++) begin
      v  = vecs[vi];
      bw = wq.size();
      bc = n_commit;
      be = n_err;
      for (int j = 0; j < v.n; j++) send(pool[v.start + j]);
      check($sformatf("v%0d_end_commit", vi), commit, (v.end_kind == 1) ? 1 : 0);
      check($sformatf("v%0d_end_err", vi), err, (v.end_kind == 2) ? 1 : 0);
      idle(3);
      check($sformatf("v%0d_nwr", vi), wq.size() - bw, v.nwr);
      for (int i = 0; i < v.nwr && bw + i < wq.size(); i++) begin
        check($sformatf("v%0d_w%0d_addr", vi, i), wq[bw+i].addr, i);
        check($sformatf("v%0d_w%0d_data", vi, i), wq[bw+i].data, pool[v.start+v.ds+i] & 8'h3F);
        check($sformatf("v%0d_w%0d_bank", vi, i), wq[bw+i].bank, !prev_bank);
      end
      check($sformatf("v%0d_commits", vi), n_commit - bc, (v.end_kind == 1) ? 1 : 0);
      check($sformatf("v%0d_errs", vi), n_err - be, (v.end_kind == 2) ? 1 : 0);
      check($sformatf("v%0d_active_bank", vi), active_bank, v.bank);
      check($sformatf("v%0d_pattern_len", vi), pattern_len, v.len);
      if (v.end_kind == 1) begin
        check($sformatf("v%0d_commit_len", vi), commit_len, v.len);
        check($sformatf("v%0d_commit_bank", vi), commit_bank, v.bank);
        check($sformatf("v%0d_commit_ready", vi), commit_ready, 0);
      end
      prev_bank = v.bank;
    end

    // Inter-byte timeout in DATA, then stray bytes with no SYNC
    bw = wq.size();
    be = n_err;
    send(8'hA5);
    send(8'h02);
    send(8'h01);
    k   = 0;
    got = 1'b0;
    while (!got && k < TIMEOUT + 10) begin
      @(posedge clk);
      #1;
      k++;
      if (err) got = 1'b1;
    end
    check("timeout_latency", k, TIMEOUT);
    idle(2);
    check("timeout_errs", n_err - be, 1);
    check("timeout_nwr", wq.size() - bw, 1);
    check("timeout_active_bank", active_bank, 1);
    check("timeout_pattern_len", pattern_len, 16);
    bw = wq.size();
    be = n_err;
    send(8'h02);
    send(8'h03);
    idle(3);
    check("stray_nwr", wq.size() - bw, 0);
    check("stray_errs", n_err - be, 0);

    // Reset in the middle of a 4-entry frame, then a normal frame
    bc = n_commit;
    send(8'hA5);
    send(8'h04);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_active_bank", active_bank, 0);
    check("midrst_pattern_len", pattern_len, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_wr_en", wr_en, 0);
    idle(2);
    check("midrst_commits", n_commit - bc, 0);
    bw = wq.size();
    send(8'hA5);
    send(8'h01);
    send(8'h3C);
    send(8'h3C);
    check("after_rst_commit", commit, 1);
    idle(3);
    check("after_rst_active_bank", active_bank, 1);
    check("after_rst_pattern_len", pattern_len, 1);
    check("after_rst_nwr", wq.size() - bw, 1);
    if (wq.size() > bw) begin
      check("after_rst_wr_data", wq[bw].data, 6'h3C);
      check("after_rst_wr_bank", wq[bw].bank, 1);
    end

    check("commit_err_exclusive", n_overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
